// File: rtl/audio_pkg.sv
// Shared audio-path constants and the slot-bit selection helper used by the
// I2S serializer.
package audio_pkg;

   localparam int AUDIO_SAMPLE_W = 16;
   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;
   localparam int I2S_BITPOS_W   = 6;

   localparam int SLOT_W    = $clog2(I2S_SLOT_BITS);
   localparam int SMP_IDX_W = $clog2(AUDIO_SAMPLE_W);

   typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

   // Bit carried at slot position s when the MSB sits at slot position 'first'.
   // Positions before the MSB wrap to large k and fall outside the sample, so
   // both the leading pad bit and the trailing pad bits come out as 0.
   function automatic logic slot_bit(input sample_t smp,
                                     input logic [SLOT_W-1:0] s,
                                     input logic [SLOT_W-1:0] first);
      logic [SLOT_W-1:0] k;
      k = s - first;
      if (k < SLOT_W'(AUDIO_SAMPLE_W))
         return smp[SMP_IDX_W'(AUDIO_SAMPLE_W-1) - k[SMP_IDX_W-1:0]];
      else
         return 1'b0;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Frame timing for the I2S transmitter: divider, BCK phase and bit position.
// Produces the registered bit clock and frame tick, plus next-cycle position
// strobes so the data path can register its outputs on the same edge.
module i2s_clkgen
   import audio_pkg::*;
#(
   parameter int BCK_DIV = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   output logic                    i2s_bck,
   output logic                    next_sample,
   output logic                    bit_start,
   output logic                    frame_last,
   output logic [I2S_BITPOS_W-1:0] bitpos_nxt
);

   localparam int DIV_W = $clog2(BCK_DIV);
   localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(BCK_DIV - 1);
   localparam logic [I2S_BITPOS_W-1:0] POS_LAST = I2S_BITPOS_W'(I2S_FRAME_BITS - 1);

   logic                    run;
   logic [DIV_W-1:0]        div, div_nxt;
   logic                    half, half_nxt;
   logic [I2S_BITPOS_W-1:0] bitpos;
   logic                    div_wrap;

   assign div_wrap = (div == DIV_LAST);

   // Next position: advance while running, otherwise park at frame start so
   // the first enabled cycle is position 0.
   always_comb begin
      div_nxt    = '0;
      half_nxt   = 1'b0;
      bitpos_nxt = '0;
      if (enable && run) begin
         div_nxt    = div_wrap ? '0 : div + 1'b1;
         half_nxt   = div_wrap ? ~half : half;
         bitpos_nxt = (div_wrap && half) ? bitpos + 1'b1 : bitpos;
      end
      frame_last = enable && run && div_wrap && half && (bitpos == POS_LAST);
      bit_start  = enable && (div_nxt == '0) && !half_nxt;
   end

   // Position counters and registered pin-side strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run         <= 1'b0;
         div         <= '0;
         half        <= 1'b0;
         bitpos      <= '0;
         i2s_bck     <= 1'b0;
         next_sample <= 1'b0;
      end else begin
         run         <= enable;
         div         <= div_nxt;
         half        <= half_nxt;
         bitpos      <= bitpos_nxt;
         i2s_bck     <= half_nxt;
         next_sample <= bit_start && (bitpos_nxt == '0);
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo serializer: 64 BCK per frame, 16-bit samples in 32-bit slots.
// Build option I2S_TX_LJ_EN selects left-justified framing (MSB at slot bit
// 0); otherwise Philips I2S framing (MSB one bit after the LRCK edge).
module i2s_tx
   import audio_pkg::*;
#(
   parameter int BCK_DIV = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [AUDIO_SAMPLE_W-1:0] left_audio,
   input  logic [AUDIO_SAMPLE_W-1:0] right_audio,
   output logic                      next_sample,
   output logic                      i2s_bck,
   output logic                      i2s_lrck,
   output logic                      i2s_data
);

`ifdef I2S_TX_LJ_EN
   localparam logic [SLOT_W-1:0] MSB_SLOT = SLOT_W'(0);
`else
   localparam logic [SLOT_W-1:0] MSB_SLOT = SLOT_W'(1);
`endif

   sample_t                 sr_left, sr_right, left_nxt, right_nxt;
   logic                    bit_start, frame_last, data_nxt;
   logic [I2S_BITPOS_W-1:0] bitpos_nxt;

   i2s_clkgen #(.BCK_DIV(BCK_DIV)) u_clkgen (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .i2s_bck     (i2s_bck),
      .next_sample (next_sample),
      .bit_start   (bit_start),
      .frame_last  (frame_last),
      .bitpos_nxt  (bitpos_nxt)
   );

   // Samples are taken only on the frame-closing edge; the outgoing bit is
   // chosen from the post-capture value so the MSB can land on bit 0 of the
   // new frame in left-justified mode.
   always_comb begin
      left_nxt  = frame_last ? left_audio  : sr_left;
      right_nxt = frame_last ? right_audio : sr_right;
      data_nxt  = slot_bit(bitpos_nxt[I2S_BITPOS_W-1] ? right_nxt : left_nxt,
                           bitpos_nxt[SLOT_W-1:0], MSB_SLOT);
   end

   // Sample holding registers and pins; LRCK/data move only at bit starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_left  <= '0;
         sr_right <= '0;
         i2s_lrck <= 1'b0;
         i2s_data <= 1'b0;
      end else if (!enable) begin
         sr_left  <= '0;
         sr_right <= '0;
         i2s_lrck <= 1'b0;
         i2s_data <= 1'b0;
      end else begin
         sr_left  <= left_nxt;
         sr_right <= right_nxt;
         if (bit_start) begin
            i2s_lrck <= bitpos_nxt[I2S_BITPOS_W-1];
            i2s_data <= data_nxt;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: expected frames are queued when the frame's
// last-cycle inputs are known and popped as the next frame is received.
module tb_i2s_tx;

   localparam int BCK_DIV   = 4;
   localparam int BIT_CYC   = 2 * BCK_DIV;
   localparam int FRAME_CYC = 64 * BIT_CYC;

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [15:0] left_audio, right_audio;
   logic        next_sample, i2s_bck, i2s_lrck, i2s_data;

   int          vecs = 0;
   int          errs = 0;
   logic [63:0] exp_q[$];

   i2s_tx #(.BCK_DIV(BCK_DIV)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .left_audio  (left_audio),
      .right_audio (right_audio),
      .next_sample (next_sample),
      .i2s_bck     (i2s_bck),
      .i2s_lrck    (i2s_lrck),
      .i2s_data    (i2s_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit i of the word is the data bit during bit period i of the frame.
   function automatic logic [63:0] frame_word(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] w;
      int off;
      w = '0;
`ifdef I2S_TX_LJ_EN
      off = 0;
`else
      off = 1;
`endif
      for (int k = 0; k < 16; k++) begin
         w[off + k]      = l[15 - k];
         w[32 + off + k] = r[15 - k];
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pins_zero(input string tag);
      check(tag, {60'd0, next_sample, i2s_bck, i2s_lrck, i2s_data}, 64'd0);
   endtask

   // Entered at cycle 0 of a frame. stop_c < FRAME_CYC aborts the frame at
   // that cycle, by reset when by_rst is set, otherwise by dropping enable.
   task automatic run_frame(input string tag, input int stop_c, input bit by_rst,
                            input int cl_c, input logic [15:0] cl_v,
                            input int cr_c, input logic [15:0] cr_v);
      logic [63:0] exp, d0, d1, lr;
      int ns_cnt, bck_bad, lr_bad, p, ph;
      check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
      exp = exp_q.pop_front();
      d0 = '0; d1 = '0; lr = '0;
      ns_cnt = 0; bck_bad = 0; lr_bad = 0;
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c == stop_c) begin
            if (by_rst) begin
               check({tag, "_pre_rst"}, {61'd0, i2s_bck, i2s_lrck, i2s_data}, 64'd7);
               #2 rst = 1'b1;
               #1 pins_zero({tag, "_async_rst"});
            end else begin
               enable = 1'b0;
               tick();
               pins_zero({tag, "_disable"});
            end
            exp_q.delete();
            return;
         end
         if (c == cl_c) left_audio = cl_v;
         if (c == cr_c) right_audio = cr_v;
         p  = c / BIT_CYC;
         ph = c % BIT_CYC;
         if (next_sample) ns_cnt++;
         if (c == 0) check({tag, "_ns_first"}, 64'(next_sample), 64'd1);
         if (i2s_bck !== (ph >= BCK_DIV)) bck_bad++;
         if (ph == 0) begin
            d0[p] = i2s_data;
            lr[p] = i2s_lrck;
         end
         if (ph == BIT_CYC - 1) begin
            d1[p] = i2s_data;
            if (i2s_lrck !== lr[p]) lr_bad++;
         end
         if (c == FRAME_CYC - 1) exp_q.push_back(frame_word(left_audio, right_audio));
         tick();
      end
      check({tag, "_data"},        d0, exp);
      check({tag, "_data_stable"}, d1, exp);
      check({tag, "_lrck"},        lr, 64'hFFFF_FFFF_0000_0000);
      check({tag, "_lrck_stable"}, 64'(lr_bad), 64'd0);
      check({tag, "_ns_count"},    64'(ns_cnt), 64'd1);
      check({tag, "_bck_shape"},   64'(bck_bad), 64'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; left_audio = '0; right_audio = '0;
      tick(); tick(); tick();
      pins_zero("reset");
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         pins_zero("idle");
      end

      // Start: first frame must be silent, then the captured pair appears.
      left_audio = 16'h8001; right_audio = 16'h7FFE;
      exp_q.push_back(64'd0);
      enable = 1'b1;
      tick();
      run_frame("f1_zero", -1, 0, -1, '0, -1, '0);
      run_frame("f2_8001", -1, 0, -1, '0, -1, '0);
      // Mid-frame left change at bitpos 20; right changed in the last cycle.
      run_frame("f3_midchg", -1, 0, 20 * BIT_CYC, 16'h1234, FRAME_CYC - 1, 16'hC3A5);
      run_frame("f4_new", -1, 0, -1, '0, -1, '0);
      // Drop enable at bitpos 40.
      run_frame("f5_stop", 40 * BIT_CYC, 0, -1, '0, -1, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         pins_zero("stopped");
      end
      // Re-enable: registers were cleared, so the first frame is silent.
      exp_q.push_back(64'd0);
      enable = 1'b1;
      tick();
      run_frame("f6_zero", -1, 0, -1, '0, -1, '0);
      run_frame("f7_resume", -1, 0, -1, '0, -1, '0);
      // Async reset during bitpos 33 with BCK high (right slot, data=1).
      run_frame("f8_rst", 33 * BIT_CYC + BCK_DIV + 1, 1, -1, '0, -1, '0);
      tick();
      pins_zero("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial DAC output stage downstream of the PCM playback block and the audio mixer. It takes the final 16-bit signed left/right samples and serializes them as a 64-bit-clock stereo frame: bit clock, word select and serial data. Once per frame it raises the `next_sample` tick that paces the PCM sample-rate accumulator. It sits at the top of the audio path, driving the external DAC pins.

## Interface
- `BCK_DIV`, default 4: clk cycles per half bit-clock period; must be ≥2. At 25 MHz this gives BCK = 3.125 MHz and a frame rate of 48.828 kHz.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run/stop control for the serializer.
- `left_audio`  in  16: left sample, signed two's complement.
- `right_audio`  in  16: right sample, signed two's complement.
- `next_sample`  out  1: one-clk pulse at each frame start.
- `i2s_bck`  out  1: bit clock.
- `i2s_lrck`  out  1: word select; 0 = left slot, 1 = right slot.
- `i2s_data`  out  1: serial data, MSB first.

## Operation
- Counters:
  - `div` runs 0..BCK_DIV-1 and marks the half-period boundary.
  - `half` is 0 (BCK low) or 1 (BCK high).
  - `bitpos` runs 0..63 and wraps to 0.
- A bit period is 2·BCK_DIV clk cycles. A frame is 64 bit periods, i.e. 128·BCK_DIV clk cycles (512 at the default).
- Slots: `bitpos` 0–31 is the left slot, 32–63 the right slot. `i2s_lrck` = `bitpos[5]`.
- Each slot carries 16 data bits; the remaining bits are 0.
  - Standard I2S: slot bit s (s = `bitpos` mod 32) carries sample[16−s] for s = 1..16, and 0 otherwise.
  - With `I2S_TX_LJ_EN`: slot bit s carries sample[15−s] for s = 0..15, and 0 otherwise.
- Sample capture: the left and right shift registers load from `left_audio`/`right_audio` on the clk edge that ends the last cycle of a frame. Inputs are ignored at all other times, so mid-frame input changes have no effect on the current frame.
- `next_sample` is high for exactly the first clk cycle of every frame (`bitpos`=0, `half`=0, `div`=0). Samples the PCM block produces in response are serialized in the following frame: one frame of latency.
- `enable` low:
  - All counters are held at 0.
  - All outputs are 0, including `next_sample`.
  - The shift registers are cleared.
- `enable` rising: the frame starts in the next cycle at position 0, with `next_sample` pulsed. The first frame outputs zeros, because the shift registers are clear.
- `enable` falling mid-frame: the serializer stops in the next cycle with no frame completion; the partial frame is discarded.
- Reset: all counters and shift registers are 0. Reset value of every output (`next_sample`, `i2s_bck`, `i2s_lrck`, `i2s_data`) is 0. Reset asserted mid-frame aborts the frame immediately (asynchronous).

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `i2s_bck` is low for the first BCK_DIV cycles of each bit period and high for the next BCK_DIV.
- `i2s_data` and `i2s_lrck` change only at a bit-period start (BCK falling edge). They are stable for BCK_DIV cycles before and after each BCK rising edge.
- Input-to-pin latency: a sample present at the last cycle of frame N appears on `i2s_data` during frame N+1:
  - Standard I2S: MSB in bit period 1 of the slot.
  - `I2S_TX_LJ_EN`: MSB in bit period 0.
- `next_sample` period: exactly 128·BCK_DIV clk cycles while enabled.

## Configuration
- `I2S_TX_LJ_EN` defined: left-justified format; the MSB coincides with the LRCK transition.
- `I2S_TX_LJ_EN` undefined: Philips I2S format; the MSB is delayed one bit period after the LRCK transition and the LSB lands at slot bit 16.
- Counters, frame length and `next_sample` timing are identical in both builds.

## Structure
- Shared package `audio_pkg` holds:
  - `AUDIO_SAMPLE_W` = 16
  - `I2S_SLOT_BITS` = 32
  - `I2S_FRAME_BITS` = 64
  - `I2S_BITPOS_W` = 6
- One sub-module, `i2s_clkgen`: owns `div`/`half`/`bitpos` and `enable`, and emits `i2s_bck`, the bit-period-start strobe, the frame-last strobe and `next_sample`.
- The top level holds the two shift registers and the data mux.

## Test plan
- Reset then `enable`=1, BCK_DIV=4: `next_sample` pulses in cycle 0 and then every 512 cycles. `i2s_bck` has a period of 8 cycles. First frame `i2s_data` is all 0.
- Drive left=16'h8001, right=16'h7FFE, standard build: second frame left slot shows bits 1..16 = 1000…0001 and right slot 0111…1110. All other slot bits are 0. `i2s_lrck` toggles at `bitpos` 32 and 0.
- Same stimulus with `I2S_TX_LJ_EN`: the MSB appears at slot bit 0, and slot bits 16–31 are 0.
- Change `left_audio` mid-frame, at `bitpos` 20: the current frame is unchanged and only the value present at the frame's last cycle is emitted next frame.
- Deassert `enable` at `bitpos` 40: all outputs are 0 the next cycle. Reassert: `next_sample` fires in the next cycle and that frame is all zeros.
- Assert `rst` asynchronously mid-bit with BCK high: `i2s_bck`, `i2s_lrck`, `i2s_data` and `next_sample` go to 0 without waiting for a clk edge.
